// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned KEY_W    = ROW_W + COL_W;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  // Index of the lowest-numbered row pulled low; 0 when none are low.
  function automatic logic [ROW_W-1:0] lowest_low(input logic [NUM_ROWS-1:0] rows_n);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running down-counter producing a one-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [15:0] RELOAD = 16'(SCAN_DIV - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (r_cnt == 16'd0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_tick = (r_cnt == 16'd0);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobe, per-tick debounce FSM and a one-deep key register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                Clk,
  input  logic                reset_n,
  output logic [NUM_COLS-1:0] cols,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                key_down,
  output logic                overrun
);

  localparam logic [3:0]          DEB  = 4'(DEBOUNCE_TICKS);
  localparam logic [NUM_COLS-1:0] COL0 = NUM_COLS'(1);

  logic [NUM_ROWS-1:0] r_sync1, r_sync2;
  state_e              r_state, w_state_next;
  logic [COL_W-1:0]    r_col, w_col_next;
  logic [ROW_W-1:0]    r_row, w_row_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [3:0]          w_cnt_inc;
  logic                w_tick;
  logic                w_any_low;
  logic                w_row_low;
  logic                w_accept;
  logic                w_key_gone;
  logic [KEY_W-1:0]    r_key_code;
  logic                r_key_valid;
  logic                r_key_down;
  logic                r_overrun;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .i_clk   (Clk),
    .i_rst_n (reset_n),
    .o_tick  (w_tick)
  );

  // rows are asynchronous to Clk; only r_sync2 is ever looked at.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
    end
  end

  assign w_any_low = ~&r_sync2;
  assign w_row_low = ~r_sync2[r_row];
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StScan;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_key_gone   = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        StScan: begin
          if (w_any_low) begin
            w_row_next = lowest_low(r_sync2);
            w_cnt_next = 4'd1;
            if (DEB == 4'd1) begin
              w_state_next = StHeld;
              w_accept     = 1'b1;
            end else begin
              w_state_next = StDebounce;
            end
          end else begin
            w_col_next = r_col + COL_W'(1);
          end
        end
        StDebounce: begin
          if (w_row_low) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc >= DEB) begin
              w_state_next = StHeld;
              w_accept     = 1'b1;
            end
          end else begin
            w_state_next = StScan;
            w_col_next   = r_col + COL_W'(1);
            w_cnt_next   = '0;
          end
        end
        StHeld: begin
          if (!w_row_low) begin
            w_state_next = StRelease;
            w_cnt_next   = 4'd1;
          end
        end
        StRelease: begin
          if (w_row_low) begin
            w_state_next = StHeld;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc >= DEB) begin
              w_state_next = StScan;
              w_col_next   = r_col + COL_W'(1);
              w_cnt_next   = '0;
              w_key_gone   = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = StScan;
        end
      endcase
    end
  end

  // An acceptance always wins over an ack in the same cycle; overrun only
  // records acceptances that clobber an unacknowledged key.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key_code  <= {w_row_next, r_col};
        r_key_valid <= 1'b1;
        r_key_down  <= 1'b1;
        if (r_key_valid && !key_ack) r_overrun <= 1'b1;
      end else begin
        if (key_ack && r_key_valid) begin
          r_key_valid <= 1'b0;
          r_overrun   <= 1'b0;
        end
        if (w_key_gone) r_key_down <= 1'b0;
      end
    end
  end

  assign cols      = ~(COL0 << r_col);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a physical key matrix drives rows, a model predicts reports.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       overrun;

  logic [15:0] pressed = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  bit   m_valid = 1'b0;
  bit   m_ovr   = 1'b0;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEB)
  ) dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 Clk = ~Clk;

  // Key matrix: a pressed key shorts its row to its column when that column is strobed low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Model of the key register seen by the consumer.
  task automatic expect_accept(input int k, input bit coincident_ack);
    exp_t e;
    if (!coincident_ack && m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    e.code  = 4'(k);
    e.ovr   = m_ovr;
    exp_q.push_back(e);
  endtask

  logic prev_down = 1'b0;

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (key_down && !prev_down) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key: got code %0d expected no report", key_code);
      end else begin
        e = exp_q.pop_front();
        check("accept_code", key_code, e.code);
        check("accept_valid", key_valid, 1);
        check("accept_overrun", overrun, e.ovr);
      end
    end
    prev_down = key_down;
  end

  task automatic wait_down(input bit val, input string name);
    int n;
    n = 0;
    while (key_down !== val && n < 80) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, key_down, val);
  endtask

  // Returns 1ns after the edge on which column c becomes the strobed column.
  task automatic wait_col(input int c);
    logic [3:0] tgt, prev;
    int n;
    bit done;
    tgt  = ~(4'b0001 << c);
    prev = cols;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge Clk);
      #1;
      n++;
      if (cols == tgt && prev != tgt) done = 1'b1;
      else if (n > 100) begin
        check("wait_col_timeout", cols, tgt);
        done = 1'b1;
      end
      prev = cols;
    end
  endtask

  task automatic tap_key(input int k, input int extra_hold);
    pressed[k] = 1'b1;
    wait_down(1'b1, "press_seen");
    repeat (extra_hold) @(posedge Clk);
    #1;
    pressed = '0;
    wait_down(1'b0, "release_seen");
  endtask

  task automatic do_ack();
    @(posedge Clk);
    #1 key_ack = 1'b1;
    @(posedge Clk);
    #1 key_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    check("ack_valid", key_valid, m_valid);
    check("ack_overrun", overrun, m_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cols"}, cols, 4'b1110);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_down"}, key_down, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    #12;
    check_reset_outputs("reset");
    @(negedge Clk) reset_n = 1'b1;

    // Idle scan: after edge i the strobed column is (i / SCAN_DIV) mod 4.
    for (int i = 1; i <= 16; i++) begin
      @(posedge Clk);
      #1;
      check("idle_cols", cols, 4'hF & ~(1 << ((i / SCAN_DIV) % 4)));
    end
    check("idle_valid", key_valid, 0);

    // Key 9 (row 2, col 1), acked while still held.
    expect_accept(9, 1'b0);
    pressed[9] = 1'b1;
    wait_down(1'b1, "key9_down");
    repeat (10) @(posedge Clk);
    #1;
    check("key9_valid_before_ack", key_valid, 1);
    do_ack();
    pressed = '0;
    wait_down(1'b0, "key9_release");

    // Key 3 low for only two ticks: rejected, scan resumes at column 0.
    wait_col(2);
    pressed[3] = 1'b1;
    wait_col(3);
    repeat (8) @(posedge Clk);
    #1 pressed = '0;
    repeat (4) @(posedge Clk);
    #1;
    check("short_resume_cols", cols, 4'b1110);
    repeat (40) @(posedge Clk);
    #1;
    check("short_no_down", key_down, 0);
    check("short_no_valid", key_valid, 0);

    // Key 5 unacked, then key 10 overruns it.
    expect_accept(5, 1'b0);
    tap_key(5, 3);
    expect_accept(10, 1'b0);
    tap_key(10, 5);
    do_ack();

    // Key 12 unacked, then key 6 accepted with an ack in the same cycle.
    expect_accept(12, 1'b0);
    tap_key(12, 2);
    wait_col(1);
    pressed[6] = 1'b1;
    expect_accept(6, 1'b1);
    wait_col(2);
    // Ticks follow at +4, +8, +12; the third low sample is the acceptance.
    repeat (11) @(posedge Clk);
    #1 key_ack = 1'b1;
    @(posedge Clk);
    #1 key_ack = 1'b0;
    check("coinc_valid", key_valid, 1);
    check("coinc_code", key_code, 6);
    check("coinc_overrun", overrun, 0);
    pressed = '0;
    wait_down(1'b0, "key6_release");
    do_ack();

    // Randomised presses with random acknowledgement.
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 15)) @(posedge Clk);
      #1;
      k = int'($urandom_range(0, 15));
      expect_accept(k, 1'b0);
      tap_key(k, int'($urandom_range(0, 20)));
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    // Key 7 left pending, then reset lands while key 15 is debouncing.
    expect_accept(7, 1'b0);
    tap_key(7, 1);
    wait_col(2);
    pressed[15] = 1'b1;
    wait_col(3);
    repeat (6) @(posedge Clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    pressed = '0;
    @(negedge Clk) reset_n = 1'b1;
    repeat (60) @(posedge Clk);
    #1;
    check("post_reset_down", key_down, 0);
    check("post_reset_valid", key_valid, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 5000, Clk cycles per column-scan tick (legal range 2..65535).
REQ-002 Parameter DEBOUNCE_TICKS, default 4, consecutive matching ticks needed to accept a press or a release (legal range 1..15).
REQ-003 Port Clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port cols  output  4  one-cold column strobe; the low bit drives the active column.
REQ-006 Port rows  input  4  active-low row returns, pulled up externally; asynchronous to Clk.
REQ-007 Port key_code  output  4  accepted key index, row*4+col.
REQ-008 Port key_valid  output  1  high while an accepted key has not been acknowledged.
REQ-009 Port key_ack  input  1  consumer acknowledge; single-cycle pulse or level.
REQ-010 Port key_down  output  1  high while the accepted key is physically held.
REQ-011 Port overrun  output  1  sticky flag; a key was accepted while key_valid was already high.

Function
REQ-012 rows SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A tick SHALL be a one-cycle pulse every SCAN_DIV cycles from a free-running down-counter reloaded at terminal count.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-015 SCAN, at each tick with all synchronized rows high: advance the column 0->1->2->3->0 (wrap), cols = ~(1<<col).
REQ-016 SCAN, at a tick with any row low: latch col plus the lowest-index low row, hold the column, set match count to 1, and go to DEBOUNCE (or to HELD directly if DEBOUNCE_TICKS=1).
REQ-017 DEBOUNCE, at each tick: if the latched row is still low, increment the count; on reaching DEBOUNCE_TICKS go to HELD. Otherwise return to SCAN and advance the column.
REQ-018 HELD, at each tick: while the latched row stays low, remain in HELD. Once it is high, go to RELEASE with count=1.
REQ-019 RELEASE, at each tick: latched row high increments the count; at DEBOUNCE_TICKS go to SCAN and advance the column. Latched row low returns to HELD.
REQ-020 On entry to HELD from DEBOUNCE (acceptance), in the following cycle: key_code = row*4+col, key_valid=1, key_down=1.
REQ-021 key_down SHALL clear on the cycle the FSM enters SCAN from RELEASE.
REQ-022 key_ack while key_valid=1 SHALL clear key_valid on the next cycle; key_ack while key_valid=0 is ignored.
REQ-023 If acceptance occurs while key_valid=1 with no ack that cycle: key_code is overwritten, key_valid stays 1, and overrun is set.
REQ-024 If acceptance and ack occur in the same cycle: the new key is latched, key_valid stays 1, and overrun is unchanged.
REQ-025 overrun SHALL clear only on an ack that is not coincident with an acceptance, or on reset.
REQ-026 Key presses on other rows or columns during DEBOUNCE, HELD or RELEASE SHALL be ignored (single-key rollover).
REQ-027 Press-to-key_valid latency SHALL be at most (4 + DEBOUNCE_TICKS)*SCAN_DIV + 3 cycles.

Reset
REQ-028 Asserting reset_n low SHALL immediately force: state=SCAN, col=0, cols=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0, tick counter=SCAN_DIV-1, match count=0, synchronizer flops=4'hF.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard the pending key, with no key_valid pulse after release.
REQ-030 Deassertion of reset SHALL take effect on a Clk edge; scanning resumes at column 0.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, NUM_ROWS=4, NUM_COLS=4, and the key_code width.
REQ-032 Tick generation SHALL be a sub-module keypad_tick_gen (counter plus tick pulse, parameter SCAN_DIV).

Verification
REQ-033 SCAN_DIV=4, DEBOUNCE_TICKS=3, no key -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid stays 0.
REQ-034 Row 2 held low while col 1 active, ack after 10 cycles -> key_code=9, key_valid=1, key_down=1; key_valid clears the cycle after ack.
REQ-035 Row 0 low for only 2 ticks on col 3 -> no key_valid, scan resumes at col 0.
REQ-036 Key 5 accepted and not acked, release, then key 10 accepted -> key_code=10, key_valid=1, overrun=1; a later ack clears both.
REQ-037 Ack coincident with acceptance of key 6 -> key_valid remains 1, key_code=6, overrun=0.
REQ-038 reset_n pulsed low while in DEBOUNCE for key 15 -> all outputs at reset values asynchronously; key 15 is never reported.
